// File: rtl/risky_run_ctrl_if.sv
// Purpose: groups the run controller's control, retire and data-memory signals with its status outputs.
// Latency: none; this is plain wiring.
// Backpressure: none; every signal is level-sampled on the controller clock.
interface risky_run_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             start;
  logic             retire;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             core_rst_n;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [31:0]      exit_code;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] instret_count;

  // Harness side: launches runs and reflects core activity.
  modport master (
    output start, retire, mem_we, mem_addr, mem_wdata,
    input  core_rst_n, busy, done, pass, timeout, exit_code, cycle_count, instret_count
  );

  // Controller side.
  modport slave (
    input  start, retire, mem_we, mem_addr, mem_wdata,
    output core_rst_n, busy, done, pass, timeout, exit_code, cycle_count, instret_count
  );
endinterface

// File: rtl/risky_run_ctrl.sv
// Purpose: holds the core in reset for RESET_CYCLES, lets it run, and ends the run on a tohost store or budget expiry.
// Latency: all outputs are registered; done rises on the edge that samples the terminating cycle.
// Backpressure: none; start is a level sampled only in IDLE/DONE, and done holds until the next start or reset.
module risky_run_ctrl #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 4096,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000
) (
  input logic           clk,
  input logic           rst_n,
  risky_run_ctrl_if.slave bus
);

  localparam int unsigned RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD    = RST_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      exit_code_q, exit_code_d;

  logic launch;
  logic tohost_hit;
  logic budget_hit;

  // A run (re)starts only from the quiescent states.
  assign launch     = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign tohost_hit = bus.mem_we && (bus.mem_addr == TOHOST_ADDR);
  // Counter still holds the pre-increment value, so this is the MAX_CYCLES-th RUN cycle.
  assign budget_hit = (cycle_cnt_q == BUDGET_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a tohost store outranks the budget.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RESET;
      S_RESET: if (rst_cnt_q == '0) state_d = S_RUN;
      S_RUN:   if (tohost_hit || budget_hit) state_d = S_DONE;
      S_DONE:  if (bus.start) state_d = S_RESET;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are registered with it.
  always_comb begin
    core_rst_n_d = (state_d == S_RUN);
    busy_d       = (state_d == S_RESET) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
  end

  // Reset countdown, run counters and result capture.
  always_comb begin
    rst_cnt_d   = rst_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    instret_d   = instret_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;
    if (launch) begin
      rst_cnt_d   = RST_LOAD;
      cycle_cnt_d = '0;
      instret_d   = '0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      exit_code_d = 32'd0;
    end else if (state_q == S_RESET) begin
      if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - RST_W'(1);
    end else if (state_q == S_RUN) begin
      // The terminating cycle is counted too.
      if (cycle_cnt_q != CNT_SAT) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (bus.retire && (instret_q != CNT_SAT)) instret_d = instret_q + CNT_W'(1);
      if (tohost_hit) begin
        exit_code_d = bus.mem_wdata;
        pass_d      = (bus.mem_wdata == 32'd1);
        timeout_d   = 1'b0;
      end else if (budget_hit) begin
        exit_code_d = 32'd0;
        pass_d      = 1'b0;
        timeout_d   = 1'b1;
      end
    end
  end

  // Datapath and output registers; an async reset discards any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q    <= '0;
      cycle_cnt_q  <= '0;
      instret_q    <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      exit_code_q  <= 32'd0;
    end else begin
      rst_cnt_q    <= rst_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instret_q    <= instret_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign bus.core_rst_n    = core_rst_n_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.timeout       = timeout_q;
  assign bus.exit_code     = exit_code_q;
  assign bus.cycle_count   = cycle_cnt_q;
  assign bus.instret_count = instret_q;

endmodule

// File: tb/tb_risky_run_ctrl.sv
module tb_risky_run_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  risky_run_ctrl_if #(.CNT_W(32)) ifa ();
  risky_run_ctrl_if #(.CNT_W(32)) ift ();

  // Long-budget instance for tohost runs.
  risky_run_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(4096), .CNT_W(32), .TOHOST_ADDR(TOHOST)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );

  // Short-budget instance for timeout runs.
  risky_run_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(16), .CNT_W(32), .TOHOST_ADDR(TOHOST)) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(ift)
  );

  task automatic clear_inputs();
    ifa.start = 1'b0; ifa.retire = 1'b0; ifa.mem_we = 1'b0; ifa.mem_addr = 32'd0; ifa.mem_wdata = 32'd0;
    ift.start = 1'b0; ift.retire = 1'b0; ift.mem_we = 1'b0; ift.mem_addr = 32'd0; ift.mem_wdata = 32'd0;
  endtask

  // Pulse start on one instance and return at the negedge after the 4th reset edge,
  // i.e. at the start of RUN cycle 1.
  task automatic launch(input bit on_t);
    @(negedge clk);
    if (on_t) ift.start = 1'b1; else ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0; ift.start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({ifa.core_rst_n, ifa.busy, ifa.done, ifa.cycle_count, ifa.instret_count} !== 67'd0) begin
        fails++; $display("FAIL reset_hold[%0d]: rstn=%b busy=%b done=%b cc=%0d ir=%0d expected all 0", i,
                          ifa.core_rst_n, ifa.busy, ifa.done, ifa.cycle_count, ifa.instret_count);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({ifa.core_rst_n, ifa.busy, ifa.done, ifa.pass, ifa.timeout, ifa.exit_code,
           ifa.cycle_count, ifa.instret_count} !== 101'd0) begin
        fails++; $display("FAIL idle[%0d]: rstn=%b busy=%b done=%b cc=%0d ir=%0d expected all 0", i,
                          ifa.core_rst_n, ifa.busy, ifa.done, ifa.cycle_count, ifa.instret_count);
      end
    end
  endtask

  // Edge T samples start; core_rst_n must stay low through T+4 and rise after it.
  // The run is then closed by a tohost store in its very first RUN cycle.
  task automatic test_reset_seq();
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    tests++;
    if ({ifa.busy, ifa.core_rst_n} !== 2'b10) begin
      fails++; $display("FAIL seq_T: busy=%b rstn=%b expected busy=1 rstn=0", ifa.busy, ifa.core_rst_n);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      tests++;
      if ({ifa.busy, ifa.core_rst_n} !== {1'b1, (i == 4)}) begin
        fails++; $display("FAIL seq_T+%0d: busy=%b rstn=%b expected busy=1 rstn=%b", i,
                          ifa.busy, ifa.core_rst_n, (i == 4));
      end
    end
    ifa.mem_we = 1'b1; ifa.mem_addr = TOHOST; ifa.mem_wdata = 32'd1;
    @(negedge clk);
    clear_inputs();
    tests++;
    if ({ifa.done, ifa.pass, ifa.cycle_count} !== {2'b11, 32'd1}) begin
      fails++; $display("FAIL first_cycle_stop: done=%b pass=%b cc=%0d expected 1 1 1",
                        ifa.done, ifa.pass, ifa.cycle_count);
    end
  endtask

  task automatic test_pass();
    launch(1'b0);
    for (int k = 1; k <= 20; k++) begin
      ifa.retire = 1'b1;
      ifa.mem_we = (k == 20); ifa.mem_addr = TOHOST; ifa.mem_wdata = 32'd1;
      @(negedge clk);
    end
    clear_inputs();
    tests++;
    if ({ifa.done, ifa.pass, ifa.timeout, ifa.busy, ifa.core_rst_n} !== 5'b11000) begin
      fails++; $display("FAIL pass_flags: done=%b pass=%b to=%b busy=%b rstn=%b expected 1 1 0 0 0",
                        ifa.done, ifa.pass, ifa.timeout, ifa.busy, ifa.core_rst_n);
    end
    tests++;
    if (ifa.exit_code !== 32'd1) begin
      fails++; $display("FAIL pass_exit: got %0d expected 1", ifa.exit_code);
    end
    tests++;
    if ({ifa.cycle_count, ifa.instret_count} !== {32'd20, 32'd20}) begin
      fails++; $display("FAIL pass_counts: cc=%0d ir=%0d expected 20 20", ifa.cycle_count, ifa.instret_count);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({ifa.done, ifa.cycle_count} !== {1'b1, 32'd20}) begin
      fails++; $display("FAIL pass_hold: done=%b cc=%0d expected 1 20", ifa.done, ifa.cycle_count);
    end
  endtask

  task automatic test_fail_decoy();
    launch(1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 6) begin
        tests++;
        if ({ifa.done, ifa.busy, ifa.core_rst_n} !== 3'b011) begin
          fails++; $display("FAIL decoy_ignored: done=%b busy=%b rstn=%b expected 0 1 1",
                            ifa.done, ifa.busy, ifa.core_rst_n);
        end
      end
      ifa.retire    = (k % 2 == 1);
      ifa.mem_we    = (k == 5) || (k == 9);
      ifa.mem_addr  = (k == 5) ? TOHOST + 32'd4 : TOHOST;
      ifa.mem_wdata = (k == 5) ? 32'd1 : 32'h7;
      @(negedge clk);
    end
    clear_inputs();
    tests++;
    if ({ifa.done, ifa.pass, ifa.timeout, ifa.exit_code} !== {3'b100, 32'h7}) begin
      fails++; $display("FAIL fail_result: done=%b pass=%b to=%b exit=%0h expected 1 0 0 7",
                        ifa.done, ifa.pass, ifa.timeout, ifa.exit_code);
    end
    tests++;
    if ({ifa.cycle_count, ifa.instret_count} !== {32'd9, 32'd5}) begin
      fails++; $display("FAIL fail_counts: cc=%0d ir=%0d expected 9 5", ifa.cycle_count, ifa.instret_count);
    end
  endtask

  task automatic test_timeout();
    launch(1'b1);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin
        tests++;
        if ({ift.done, ift.cycle_count} !== {1'b0, 32'd15}) begin
          fails++; $display("FAIL to_early: done=%b cc=%0d expected 0 15", ift.done, ift.cycle_count);
        end
      end
      ift.retire = 1'b1;
      @(negedge clk);
    end
    clear_inputs();
    tests++;
    if ({ift.done, ift.timeout, ift.pass, ift.exit_code} !== {3'b110, 32'd0}) begin
      fails++; $display("FAIL to_result: done=%b to=%b pass=%b exit=%0h expected 1 1 0 0",
                        ift.done, ift.timeout, ift.pass, ift.exit_code);
    end
    tests++;
    if ({ift.cycle_count, ift.instret_count} !== {32'd16, 32'd16}) begin
      fails++; $display("FAIL to_counts: cc=%0d ir=%0d expected 16 16", ift.cycle_count, ift.instret_count);
    end
    // Store on the budget cycle itself: tohost wins.
    launch(1'b1);
    for (int k = 1; k <= 16; k++) begin
      ift.mem_we = (k == 16); ift.mem_addr = TOHOST; ift.mem_wdata = 32'd1;
      @(negedge clk);
    end
    clear_inputs();
    tests++;
    if ({ift.done, ift.pass, ift.timeout, ift.exit_code, ift.cycle_count, ift.instret_count}
        !== {3'b110, 32'd1, 32'd16, 32'd0}) begin
      fails++; $display("FAIL to_tie: done=%b pass=%b to=%b exit=%0h cc=%0d ir=%0d expected 1 1 0 1 16 0",
                        ift.done, ift.pass, ift.timeout, ift.exit_code, ift.cycle_count, ift.instret_count);
    end
  endtask

  task automatic test_restart();
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    tests++;
    if ({ifa.done, ifa.busy, ifa.pass, ifa.exit_code, ifa.cycle_count, ifa.instret_count}
        !== {3'b010, 96'd0}) begin
      fails++; $display("FAIL restart_clear: done=%b busy=%b pass=%b exit=%0h cc=%0d ir=%0d expected 0 1 0 0 0 0",
                        ifa.done, ifa.busy, ifa.pass, ifa.exit_code, ifa.cycle_count, ifa.instret_count);
    end
    repeat (4) @(negedge clk);
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) begin
        tests++;
        if ({ifa.busy, ifa.core_rst_n, ifa.cycle_count} !== {2'b11, 32'd4}) begin
          fails++; $display("FAIL start_in_run: busy=%b rstn=%b cc=%0d expected 1 1 4",
                            ifa.busy, ifa.core_rst_n, ifa.cycle_count);
        end
      end
      ifa.start  = (k == 3);
      ifa.retire = 1'b1;
      ifa.mem_we = (k == 6); ifa.mem_addr = TOHOST; ifa.mem_wdata = 32'hA5;
      @(negedge clk);
    end
    clear_inputs();
    tests++;
    if ({ifa.done, ifa.pass, ifa.exit_code, ifa.cycle_count, ifa.instret_count}
        !== {2'b10, 32'hA5, 32'd6, 32'd6}) begin
      fails++; $display("FAIL restart_run: done=%b pass=%b exit=%0h cc=%0d ir=%0d expected 1 0 a5 6 6",
                        ifa.done, ifa.pass, ifa.exit_code, ifa.cycle_count, ifa.instret_count);
    end
  endtask

  task automatic test_abort();
    launch(1'b0);
    for (int k = 1; k <= 5; k++) begin
      ifa.retire = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ifa.core_rst_n, ifa.busy, ifa.done, ifa.pass, ifa.timeout, ifa.exit_code,
         ifa.cycle_count, ifa.instret_count} !== 101'd0) begin
      fails++; $display("FAIL abort: rstn=%b busy=%b done=%b cc=%0d ir=%0d expected all 0",
                        ifa.core_rst_n, ifa.busy, ifa.done, ifa.cycle_count, ifa.instret_count);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({ifa.busy, ifa.done, ifa.core_rst_n} !== 3'b000) begin
      fails++; $display("FAIL abort_idle: busy=%b done=%b rstn=%b expected 0 0 0",
                        ifa.busy, ifa.done, ifa.core_rst_n);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_reset_seq();
    test_pass();
    test_fail_decoy();
    test_timeout();
    test_restart();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/risky_run_ctrl.md
# risky_run_ctrl

Synthesizable run controller for the `risky` core, sitting between the top-level clock/reset and the core's reset input.
- Sequences the core reset for a parametrised number of cycles, then lets the core run.
- Counts cycles and retired instructions, and watches the data-memory write port for a store to the `tohost` address.
- Ends the run on that store, or on a cycle-budget timeout, and reports pass/fail/timeout plus an exit code.
- Generalises a fixed "reset one cycle, run N cycles, stop" harness into a reusable block for simulation benches and FPGA bring-up.

## Interface
Parameters:
- RESET_CYCLES, 4: cycles `core_rst_n` is held low after `start` (≥1).
- MAX_CYCLES, 4096: run-cycle budget before timeout (≥1, < 2^CNT_W).
- CNT_W, 32: width of the cycle and instret counters.
- TOHOST_ADDR, 32'h0000_1000: store address that terminates a run.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled in IDLE and DONE only
- retire  in  1  core retired one instruction this cycle
- mem_we  in  1  core data-memory write enable
- mem_addr  in  32  core data-memory address
- mem_wdata  in  32  core data-memory write data
- core_rst_n  out  1  active-low reset to the core, registered
- busy  out  1  high in RESET and RUN
- done  out  1  high in DONE
- pass  out  1  run ended by a tohost store of 32'd1
- timeout  out  1  run ended by the cycle budget
- exit_code  out  32  value of the terminating tohost store; 0 on timeout
- cycle_count  out  CNT_W  RUN cycles elapsed
- instret_count  out  CNT_W  retired instructions during RUN

## Operation
- FSM states: IDLE, RESET, RUN, DONE. All outputs are registered.
- Reset (rst_n=0, async): state=IDLE; core_rst_n=0, busy=0, done=0, pass=0, timeout=0, exit_code=0, counters=0.
- IDLE:
  - core_rst_n=0.
  - start=1 → RESET; clear counters, pass, timeout and exit_code; load the reset counter with RESET_CYCLES-1.
- RESET:
  - core_rst_n=0, busy=1.
  - The reset counter decrements each cycle; at 0 → RUN.
  - start is ignored.
- RUN:
  - core_rst_n=1, busy=1.
  - cycle_count += 1 every cycle.
  - instret_count += 1 on each cycle with retire=1.
  - Both counters saturate at all-ones.
- Terminate on tohost: mem_we=1 and mem_addr==TOHOST_ADDR → DONE.
  - exit_code=mem_wdata.
  - pass=(mem_wdata==32'd1).
  - timeout=0.
- Terminate on timeout: no tohost store and cycle_count==MAX_CYCLES-1 → DONE with timeout=1, pass=0, exit_code=0.
- Terminating cycle accounting: the terminating cycle is counted in cycle_count, and in instret_count if retire=1.
- Simultaneous tohost store and timeout: tohost wins, timeout=0.
- Writes to other addresses have no effect.
- DONE:
  - core_rst_n=0 (core frozen), busy=0, done=1.
  - Results and counters hold.
  - start=1 → RESET (restart): clears results and counters, done falls.
- Async reset mid-run returns to IDLE immediately; results are lost.

## Timing
- start sampled high at edge T:
  - busy=1 after T.
  - core_rst_n stays 0 through edge T+RESET_CYCLES; rises after edge T+RESET_CYCLES.
- The first RUN cycle follows the RESET_CYCLES-th RESET cycle.
- Termination observed at edge E (tohost store or budget cycle):
  - done=1, busy=0, core_rst_n=0 from E onward.
  - Latency from the store to done is one edge.
- Timeout run: done rises after exactly MAX_CYCLES RUN cycles, with cycle_count=MAX_CYCLES.
- Start-to-done for a timeout run: RESET_CYCLES+MAX_CYCLES edges.
- No handshake on done: it is level and holds until the next start or rst_n.

## Test plan
- Reset then idle: rst_n low 3 cycles, then high, start=0 for 10 cycles → core_rst_n=0, busy=0, done=0, counters=0 throughout.
- Reset sequencing, RESET_CYCLES=4: start pulse at edge T → core_rst_n low through T+4, high after; busy high from T.
- Pass run:
  - Stimulus: retire=1 every cycle; at RUN cycle 20, mem_we=1, addr=TOHOST_ADDR, wdata=1.
  - Response: done=1, pass=1, exit_code=1, cycle_count=20, instret_count=20, core_rst_n=0.
- Fail and decoy:
  - Stimulus: store to TOHOST_ADDR+4 at cycle 5, then tohost wdata=32'h7 at cycle 9.
  - Response: run continues past cycle 5; done at cycle 9 with pass=0, exit_code=7.
- Timeout, MAX_CYCLES=16: no tohost store → done after 16 RUN cycles with timeout=1, pass=0, cycle_count=16. Second case: tohost store wdata=1 on RUN cycle 16 → pass=1, timeout=0.
- Restart and abort:
  - start in DONE → counters cleared, new run completes normally.
  - start during RUN is ignored.
  - rst_n asserted mid-RUN → immediate IDLE with all outputs at reset values.
